// File: rtl/spr_re_gamma_pkg.sv
// Shared types and constants for the SPR re-gamma LUT controller.
package spr_re_gamma_pkg;

    localparam int LUT_ADDR_W = 10;
    localparam int LUT_DATA_W = 11;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        WAIT_VS = 2'd2
    } state_e;

    localparam logic [1:0] CH_R   = 2'd0;
    localparam logic [1:0] CH_G   = 2'd1;
    localparam logic [1:0] CH_B   = 2'd2;
    localparam logic [1:0] CH_ALL = 2'd3;

    function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
        logic [2:0] sel;
        case (ch)
            CH_R:    sel = 3'b001;
            CH_G:    sel = 3'b010;
            CH_B:    sel = 3'b100;
            CH_ALL:  sel = 3'b111;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/spr_re_gamma_lut_ctrl_if.sv
// Host entry-write / commit interface of the re-gamma LUT controller.
interface spr_re_gamma_lut_ctrl_if
    import spr_re_gamma_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
);
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [1:0]        host_wr_ch;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_commit;

    modport master (
        output host_wr_valid, host_wr_ch, host_wr_addr, host_wr_data, host_commit,
        input  host_wr_ready
    );

    modport slave (
        input  host_wr_valid, host_wr_ch, host_wr_addr, host_wr_data, host_commit,
        output host_wr_ready
    );
endinterface

// File: rtl/spr_vs_edge_det.sv
// Vertical-sync rising-edge detector (one register stage).
module spr_vs_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_i,
    output logic vs_rise_o
);
    logic vs_d_q;

    // Previous-cycle copy of vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_q <= 1'b0;
        end else begin
            vs_d_q <= vs_i;
        end
    end

    assign vs_rise_o = vs_i & ~vs_d_q;
endmodule

// File: rtl/spr_re_gamma_lut_ctrl.sv
// Double-banked re-gamma LUT controller: ramp fill, host writes, frame-aligned bank swap.
// Optional SPR_RE_GAMMA_CHECKSUM_EN adds the shadow_csum readback accumulator.
module spr_re_gamma_lut_ctrl
    import spr_re_gamma_pkg::*;
#(
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int DATA_W = LUT_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vs,
    input  logic                    cfg_re_gamma_en,
    spr_re_gamma_lut_ctrl_if.slave  host,
    output logic                    commit_pending,
    output logic                    commit_done,
    output logic                    init_busy,
    output logic                    lut_wr_en,
    output logic [2:0]              lut_wr_ch_sel,
    output logic                    lut_wr_bank,
    output logic [ADDR_W-1:0]       lut_wr_addr,
    output logic [DATA_W-1:0]       lut_wr_data,
    output logic                    lut_rd_bank,
    output logic                    spr_re_gamma_en
`ifdef SPR_RE_GAMMA_CHECKSUM_EN
    ,
    output logic [15:0]             shadow_csum
`endif
);
    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fill_done_q;
    logic              commit_latch_q;
    logic              host_wr_ready_q;
    logic              commit_pending_q;
    logic              commit_done_q;
    logic              init_busy_q;
    logic              lut_wr_en_q;
    logic [2:0]        lut_wr_ch_sel_q;
    logic              lut_wr_bank_q;
    logic [ADDR_W-1:0] lut_wr_addr_q;
    logic [DATA_W-1:0] lut_wr_data_q;
    logic              lut_rd_bank_q;
    logic              spr_en_q;
    logic              vs_rise_s;
    logic              wr_acc_s;

    spr_vs_edge_det u_vs_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs_i      (i_vs),
        .vs_rise_o (vs_rise_s)
    );

    assign wr_acc_s = host.host_wr_valid & host_wr_ready_q;

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= INIT;
            cnt_q            <= {CNT_W{1'b0}};
            fill_done_q      <= 1'b0;
            commit_latch_q   <= 1'b0;
            host_wr_ready_q  <= 1'b0;
            commit_pending_q <= 1'b0;
            commit_done_q    <= 1'b0;
            init_busy_q      <= 1'b1;
            lut_wr_en_q      <= 1'b0;
            lut_wr_ch_sel_q  <= 3'b000;
            lut_wr_bank_q    <= 1'b0;
            lut_wr_addr_q    <= {ADDR_W{1'b0}};
            lut_wr_data_q    <= {DATA_W{1'b0}};
            lut_rd_bank_q    <= 1'b0;
            spr_en_q         <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (host.host_commit) begin
                        commit_latch_q <= 1'b1;
                    end
                    if (!fill_done_q) begin
                        // Identity ramp into both banks: entry = addr scaled by 2.
                        lut_wr_en_q     <= 1'b1;
                        lut_wr_ch_sel_q <= 3'b111;
                        lut_wr_bank_q   <= cnt_q[ADDR_W];
                        lut_wr_addr_q   <= cnt_q[ADDR_W-1:0];
                        lut_wr_data_q   <= {cnt_q[ADDR_W-1:0], 1'b0};
                        cnt_q           <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_q == {CNT_W{1'b1}}) begin
                            fill_done_q <= 1'b1;
                        end
                    end else begin
                        lut_wr_en_q    <= 1'b0;
                        lut_wr_bank_q  <= ~lut_rd_bank_q;
                        init_busy_q    <= 1'b0;
                        commit_latch_q <= 1'b0;
                        if (commit_latch_q | host.host_commit) begin
                            state_q          <= WAIT_VS;
                            commit_pending_q <= 1'b1;
                            host_wr_ready_q  <= 1'b0;
                        end else begin
                            state_q          <= IDLE;
                            host_wr_ready_q  <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    commit_done_q <= 1'b0;
                    lut_wr_bank_q <= ~lut_rd_bank_q;
                    if (vs_rise_s) begin
                        spr_en_q <= cfg_re_gamma_en;
                    end
                    if (wr_acc_s) begin
                        lut_wr_en_q     <= 1'b1;
                        lut_wr_ch_sel_q <= ch_onehot(host.host_wr_ch);
                        lut_wr_addr_q   <= host.host_wr_addr;
                        lut_wr_data_q   <= host.host_wr_data;
                    end else begin
                        lut_wr_en_q     <= 1'b0;
                    end
                    if (host.host_commit) begin
                        state_q          <= WAIT_VS;
                        commit_pending_q <= 1'b1;
                        host_wr_ready_q  <= 1'b0;
                    end
                end
                WAIT_VS: begin
                    lut_wr_en_q <= 1'b0;
                    if (vs_rise_s) begin
                        lut_rd_bank_q    <= ~lut_rd_bank_q;
                        lut_wr_bank_q    <= lut_rd_bank_q;
                        spr_en_q         <= cfg_re_gamma_en;
                        commit_done_q    <= 1'b1;
                        commit_pending_q <= 1'b0;
                        host_wr_ready_q  <= 1'b1;
                        state_q          <= IDLE;
                    end else begin
                        commit_done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= INIT;
                    cnt_q            <= {CNT_W{1'b0}};
                    fill_done_q      <= 1'b0;
                    commit_pending_q <= 1'b0;
                    commit_done_q    <= 1'b0;
                    host_wr_ready_q  <= 1'b0;
                    init_busy_q      <= 1'b1;
                    lut_wr_en_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPR_RE_GAMMA_CHECKSUM_EN
    logic [15:0] csum_q;

    // Sum of host-written entries since the last swap; clears as commit_done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 16'd0;
        end else if ((state_q == WAIT_VS) && vs_rise_s) begin
            csum_q <= 16'd0;
        end else if ((state_q == IDLE) && wr_acc_s) begin
            csum_q <= csum_q + 16'(host.host_wr_data);
        end else begin
            csum_q <= csum_q;
        end
    end

    assign shadow_csum = csum_q;
`endif

    assign host.host_wr_ready = host_wr_ready_q;
    assign commit_pending     = commit_pending_q;
    assign commit_done        = commit_done_q;
    assign init_busy          = init_busy_q;
    assign lut_wr_en          = lut_wr_en_q;
    assign lut_wr_ch_sel      = lut_wr_ch_sel_q;
    assign lut_wr_bank        = lut_wr_bank_q;
    assign lut_wr_addr        = lut_wr_addr_q;
    assign lut_wr_data        = lut_wr_data_q;
    assign lut_rd_bank        = lut_rd_bank_q;
    assign spr_re_gamma_en    = spr_en_q;
endmodule

// File: doc/spr_re_gamma_lut_ctrl.md
Name: spr_re_gamma_lut_ctrl

Overview:
Configuration controller for the SPR re-gamma stage's per-channel LUTs (R/G/B, shared by all four pixel lanes). Each LUT memory is double-banked: the datapath reads the active bank while this block writes the shadow bank. The block fills both banks with a linear ramp after reset and accepts host entry writes through a valid/ready handshake. On host commit it swaps banks, and updates the datapath enable, only at a frame boundary (i_vs rising edge), so no frame ever mixes two tables.

Parameters:
ADDR_W, 10, LUT address width (re-gamma input width)
DATA_W, 11, LUT entry width (re-gamma output width); must be ADDR_W+1

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
i_vs  in  1  vertical sync, synchronous to clk, active-high
cfg_re_gamma_en  in  1  requested re-gamma enable
host_wr_valid  in  1  host entry write request
host_wr_ready  out  1  controller can accept a host write
host_wr_ch  in  2  0=R, 1=G, 2=B, 3=broadcast to all three
host_wr_addr  in  ADDR_W  entry index
host_wr_data  in  DATA_W  entry value
host_commit  in  1  single-cycle request to swap banks at next frame boundary
commit_pending  out  1  commit accepted, awaiting i_vs edge
commit_done  out  1  one-cycle pulse on swap
init_busy  out  1  reset ramp fill in progress
lut_wr_en  out  1  LUT write strobe
lut_wr_ch_sel  out  3  one-hot channel select {B,G,R}
lut_wr_bank  out  1  bank written (always the shadow bank outside INIT)
lut_wr_addr  out  ADDR_W  LUT write address
lut_wr_data  out  DATA_W  LUT write data
lut_rd_bank  out  1  active bank read by datapath
spr_re_gamma_en  out  1  enable to datapath, frame-aligned

Behaviour:
- Reset values: host_wr_ready=0, commit_pending=0, commit_done=0, init_busy=1, lut_wr_en=0, lut_wr_ch_sel=0, lut_wr_bank=0, lut_wr_addr=0, lut_wr_data=0, lut_rd_bank=0, spr_re_gamma_en=0. FSM enters INIT.
- vs_rise = i_vs & ~i_vs_d (one register); i_vs_d resets to 0.
- INIT: counter {bank,addr} runs 0..2^(ADDR_W+1)-1. Each cycle it asserts lut_wr_en with ch_sel=3'b111, bank=cnt MSB, addr=cnt LSBs, data={addr,1'b0}. The fill takes 2048 cycles at defaults. After the last write, init_busy falls on the next cycle and the FSM goes to IDLE.
- IDLE: host_wr_ready=1. An accepted write (valid&ready) is registered and drives lut_wr_* the next cycle (latency 1): bank=~lut_rd_bank, ch_sel is one-hot of ch, ch=3 gives 3'b111.
- Commit: host_commit in IDLE moves the FSM to WAIT_VS and raises commit_pending. A write accepted in the same cycle as host_commit is still performed and is included.
- A commit during INIT is latched and takes effect on INIT exit, so the FSM goes directly to WAIT_VS.
- A commit during WAIT_VS is ignored.
- WAIT_VS: host_wr_ready=0, so the shadow bank is frozen. On vs_rise, lut_rd_bank toggles, spr_re_gamma_en takes cfg_re_gamma_en, and commit_done pulses, all registered (visible the cycle after vs_rise). commit_pending then clears and the FSM returns to IDLE.
- Enable change without commit: spr_re_gamma_en also loads cfg_re_gamma_en on any vs_rise in IDLE. It never changes mid-frame.
- After a swap the new shadow bank holds the older table. The host must rewrite every entry it relies on before the next commit.
- vs_rise during INIT: no swap and no enable update.
- Reset asserted mid-operation: immediate return to reset values. Any pending commit and any partial writes are discarded, and INIT restarts.

Optional Feature:
SPR_RE_GAMMA_CHECKSUM_EN:
- Defined: adds output shadow_csum[15:0]. It is the modulo-2^16 sum of lut_wr_data over host writes since the last commit_done, counted once per write even for broadcast. It clears to 0 on reset and in the cycle commit_done is asserted; a write in that same cycle starts the new sum. This gives firmware a readback check.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package spr_re_gamma_pkg: ADDR_W/DATA_W defaults, the FSM state enum (INIT, IDLE, WAIT_VS), and the channel code constants (CH_R=0, CH_G=1, CH_B=2, CH_ALL=3).
- One sub-module, spr_vs_edge_det: the i_vs register and the rising-edge pulse. Everything else stays flat.

Test Plan:
- Reset release: 2048 writes; addr 5 in bank 1 receives data 10 with ch_sel=111; init_busy=0 at cycle 2049; host_wr_ready=1 after that.
- Host write ch=1, addr=0x3FF, data=0x7AB in IDLE with lut_rd_bank=0: next cycle lut_wr_en=1, ch_sel=010, bank=1, addr=0x3FF, data=0x7AB.
- host_commit with cfg_re_gamma_en=1, i_vs rising 100 cycles later: host_wr_ready=0 and commit_pending=1 throughout the wait. The cycle after the edge: lut_rd_bank=1, spr_re_gamma_en=1, commit_done pulses for 1 cycle.
- host_commit asserted at INIT cycle 500: no swap during INIT; commit_pending=1 after INIT; swap on first vs_rise after INIT.
- cfg_re_gamma_en toggled mid-frame with no commit: spr_re_gamma_en unchanged until the next vs_rise; lut_rd_bank unchanged.
- rst_n pulsed low while in WAIT_VS: all outputs return to reset values asynchronously and INIT restarts from addr 0. With SPR_RE_GAMMA_CHECKSUM_EN: writes of data 0x100 and 0x200 give shadow_csum=0x300, which clears at commit_done.
